// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op encodings (iOp field of hilo_muldiv_ctrl)
//   - sequencer state encoding
//   - default operand width
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Bit 1 of the op selects divide, bit 0 selects unsigned.
    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative multiply/divide.
//   isDiv   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc     : current accumulator {hi, lo}
//             multiply: {partial product, unprocessed multiplier bits}
//             divide  : {partial remainder, dividend/quotient bits}
//   opnd    : multiplicand (multiply) or divisor (divide), magnitude form
//   nextAcc : accumulator after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              isDiv,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] nextAcc
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: the carry out of the add becomes the new MSB after the shift.
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: the shifted remainder can need XLEN+1 bits (it is < 2*divisor).
        trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff  = trial - {1'b0, opnd};
        if (isDiv) begin
            if (!diff[XLEN])
                nextAcc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                nextAcc = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            nextAcc = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer feeding HI/LO.
// Operands are converted to magnitudes, run through XLEN shift-add or
// restoring-divide steps, sign-corrected in FIX, then written in DONE.
// Optional build macro MULDIV_EARLY_EXIT_EN: a multiply whose remaining
// multiplier bits are all zero finishes its outstanding shifts in one cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   iStart, iOp     start request (sampled in IDLE) and op select
//   iA, iB          rs / rt operand values
//   iReadHL         MFHI/MFLO in ID needs HI/LO
//   oBusy, oStall   sequencer busy, pipeline freeze
//   oHiLoWrite      one-cycle HI/LO write strobe (same as oDone)
//   oHi, oLo        result (remainder / quotient for divide)
//   oDone           one-cycle completion pulse
//   oDivZero        divisor was zero, valid with oDone
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iStart,
    input  logic [1:0]      iOp,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    input  logic            iReadHL,
    output logic            oBusy,
    output logic            oStall,
    output logic            oHiLoWrite,
    output logic [XLEN-1:0] oHi,
    output logic [XLEN-1:0] oLo,
    output logic            oDone,
    output logic            oDivZero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_e            state, nextState;
    logic [CNT_W-1:0]  cnt;
    op_e               opReg;
    logic              signA, signB;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc, stepNext, runNext;
    logic [XLEN-1:0]   hiReg, loReg, fixHi, fixLo;
    logic              divZeroReg;
    logic              earlyExit;

    // Operand decode in IDLE
    logic            startDiv, startSigned, aNeg, bNeg, divByZero;
    logic [XLEN-1:0] magA, magB;

    assign startDiv    = isDivOp(iOp);
    assign startSigned = isSignedOp(iOp);
    assign aNeg        = startSigned & iA[XLEN-1];
    assign bNeg        = startSigned & iB[XLEN-1];
    assign magA        = aNeg ? -iA : iA;
    assign magB        = bNeg ? -iB : iB;
    assign divByZero   = startDiv && (iB == '0);

    muldiv_step #(.XLEN(XLEN)) uStep (
        .isDiv  (isDivOp(opReg)),
        .acc    (acc),
        .opnd   (opnd),
        .nextAcc(stepNext)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    // Unprocessed multiplier bits above the one consumed this step sit in
    // lo[XLEN-cnt-1:1]; once they are zero the remaining steps are pure shifts.
    assign earlyExit = !isDivOp(opReg) &&
                       (((acc[XLEN-1:0] >> 1) & ({XLEN{1'b1}} >> (cnt + 1'b1))) == '0);
    assign runNext   = earlyExit ? (stepNext >> (LAST_STEP - cnt)) : stepNext;
`else
    assign earlyExit = 1'b0;
    assign runNext   = stepNext;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next state
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (iStart) nextState = divByZero ? DONE : RUN;
            RUN:  if (cnt == LAST_STEP || earlyExit) nextState = FIX;
            FIX:  nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Sign correction applied while in FIX
    always_comb begin
        fixHi = acc[2*XLEN-1:XLEN];
        fixLo = acc[XLEN-1:0];
        case (opReg)
            OP_MULT: if (signA ^ signB) {fixHi, fixLo} = -acc;
            OP_DIV: begin
                if (signA ^ signB) fixLo = -acc[XLEN-1:0];
                if (signA)         fixHi = -acc[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            opReg      <= OP_MULT;
            signA      <= 1'b0;
            signB      <= 1'b0;
            opnd       <= '0;
            acc        <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            divZeroReg <= 1'b0;
        end else begin
            divZeroReg <= 1'b0;
            case (state)
                IDLE: if (iStart) begin
                    opReg <= op_e'(iOp);
                    signA <= aNeg;
                    signB <= bNeg;
                    cnt   <= '0;
                    if (divByZero) begin
                        hiReg      <= iA;
                        loReg      <= '1;
                        divZeroReg <= 1'b1;
                    end else begin
                        opnd <= startDiv ? magB : magA;
                        acc  <= {{XLEN{1'b0}}, startDiv ? magA : magB};
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    acc <= runNext;
                end
                FIX: begin
                    hiReg <= fixHi;
                    loReg <= fixLo;
                    cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign oBusy      = (state != IDLE);
    assign oStall     = oBusy & (iReadHL | iStart);
    assign oHiLoWrite = (state == DONE);
    assign oDone      = (state == DONE);
    assign oHi        = hiReg;
    assign oLo        = loReg;
    assign oDivZero   = divZeroReg;

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer feeding the HI/LO register pair from the EX stage.
- Accepts MULT/MULTU/DIV/DIVU operands decoded into the ID/EX stage.
- Runs a 32-step shift-add multiply or restoring divide.
- Raises a pipeline stall while busy, then pulses a HI/LO write with the 64-bit result.

Parameters:
XLEN, 32, operand width; HI/LO are each XLEN bits.
CNT_W, 6, iteration counter width; must hold values 0..XLEN.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  synchronous, active-high reset.
iStart  in  1  start request; sampled only in IDLE.
iOp  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
iA  in  XLEN  multiplicand / dividend (rs value from ID/EX).
iB  in  XLEN  multiplier / divisor (rt value from ID/EX).
iReadHL  in  1  an MFHI/MFLO in ID needs HI/LO this cycle.
oBusy  out  1  high in any state other than IDLE.
oStall  out  1  freeze PC, IF/ID and ID/EX.
oHiLoWrite  out  1  one-cycle write strobe to the HI/LO registers.
oHi  out  XLEN  result high word (remainder for divide).
oLo  out  XLEN  result low word (quotient for divide).
oDone  out  1  one-cycle completion pulse; coincides with oHiLoWrite.
oDivZero  out  1  divisor was zero; valid while oDone is high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE, counter to 0.
  - All outputs go to 0, including oHi and oLo.
  - Reset applied mid-operation aborts the operation with no oHiLoWrite.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - iStart=1 latches iOp, |iA| and |iB| (magnitudes for signed ops, raw values for unsigned ops) plus both operand signs, clears the accumulator and moves to RUN.
  - Exception: a DIV/DIVU with iB==0 moves straight to DONE and loads oHi=iA, oLo={XLEN{1}}, oDivZero=1.
- RUN: one step per cycle for exactly XLEN cycles (counter 0..XLEN-1), then FIX.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift the 2*XLEN product right by 1.
  - Divide: shift the remainder:quotient pair left by 1; trial-subtract the divisor; keep the result and set the quotient bit if it is non-negative.
- FIX (1 cycle): sign correction.
  - Signed multiply with differing operand signs: negate the 64-bit product (two's complement).
  - Signed divide: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
  - INT_MIN / -1 gives quotient 0x80000000 and remainder 0, with no trap.
- DONE (1 cycle): oHiLoWrite=1 and oDone=1; oHi/oLo present the result. Next state is IDLE.
- Latency: start accepted at cycle 0; DONE at cycle XLEN+2 (cycle 34 by default). Divide-by-zero reaches DONE at cycle 1.
- oHi/oLo hold the last result in IDLE and update only on entry to DONE.
- oStall = (oBusy & iReadHL) | (oBusy & iStart).
  - DONE counts as busy, so a reader stalled in DONE sees the new HI/LO on the next cycle.
  - iStart while busy is ignored (not queued); the requester stays stalled and retries.
  - iStart in IDLE does not stall; the instruction proceeds while the operation runs.
- oDivZero clears on the cycle after DONE.

Optional Feature:
Macro MULDIV_EARLY_EXIT_EN.
- Defined: in RUN, a multiply whose remaining unshifted multiplier bits are all zero completes the outstanding shifts in one cycle, then goes to FIX. Latency becomes (index of highest set bit of |iB|) + 3 cycles, minimum 3. Divide timing is unchanged.
- Undefined: multiply always takes the fixed XLEN+2 latency; result values are identical in both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state encoding: IDLE, RUN, FIX, DONE;
  - XLEN_DEFAULT.
- One sub-module, muldiv_step: a combinational single iteration (add-shift or subtract-shift) taking op and the current accumulator, returning the next accumulator. The FSM, counter, sign fix and stall logic remain in hilo_muldiv_ctrl.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> cycle 34: oHiLoWrite=1, oHi=0xFFFFFFFE, oLo=0x00000001.
2. MULT A=0xFFFFFFFD (-3), B=5 -> oHi=0xFFFFFFFF, oLo=0xFFFFFFF1; with MULDIV_EARLY_EXIT_EN, done at cycle 5.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> oLo=0xFFFFFFFD, oHi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> oLo=0x80000000, oHi=0.
4. DIVU A=10, B=0 -> cycle 1: oDone=1, oDivZero=1, oHi=0x0000000A, oLo=0xFFFFFFFF.
5. iReadHL=1 at cycle 5 of a MULTU -> oStall=1 from cycle 5 through DONE (cycle 34), 0 at cycle 35; a second iStart at cycle 10 is ignored and old HI/LO is not overwritten twice.
6. rst=1 at RUN cycle 10 -> next cycle IDLE, oBusy=0, oStall=0, oHi=oLo=0; no oHiLoWrite within the following 40 cycles.
